jtframe_dwnld_buf: RTL and testbench

- Download front-end between the ioctl byte stream and the SDRAM programming port (prog_*), feeding the game_sdram wrapper's prog bus.
- Classifies each ioctl byte into an SDRAM bank or PROM space and buffers SDRAM byte-writes in a small FIFO.
- Drains the FIFO through a we/ack/rdy handshake, so ioctl bursts never stall on SDRAM refresh or bank contention.
- Drives dwnld_busy until the last byte is committed.

---
 rtl/jtframe_dwnld_pkg.sv | 12 +
 rtl/jtframe_dwnld_fifo.sv | 46 ++++
 rtl/jtframe_dwnld_buf.sv | 126 ++++++++++++
 tb/tb_jtframe_dwnld_buf.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/jtframe_dwnld_pkg.sv
// jtframe_dwnld_pkg: drain FSM states, FIFO entry layout and lane masks shared by the download buffer.
package jtframe_dwnld_pkg;
    typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;
    typedef struct packed {
        logic [1:0]  ba;
        logic [21:0] addr;
        logic [15:0] data;
        logic [1:0]  mask;
    } entry_t;
    localparam logic [1:0] MASK_HI = 2'b01;
    localparam logic [1:0] MASK_LO = 2'b10;
endpackage

// File: rtl/jtframe_dwnld_fifo.sv
// jtframe_dwnld_fifo: synchronous FIFO of SDRAM byte-writes.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module jtframe_dwnld_fifo
    import jtframe_dwnld_pkg::*;
#(
    parameter int DEPTH = 8,
    localparam int AW = $clog2(DEPTH)
)(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        push,
    input  logic        pop,
    input  entry_t      din,
    output entry_t      dout,
    output logic        full,
    output logic        empty,
    output logic [AW:0] count
);
    entry_t        mem [DEPTH];
    logic [AW-1:0] wp_q, rp_q;
    logic [AW:0]   cnt_q, cnt_d;
    logic          wr, rd;

    assign empty = cnt_q == '0;
    assign full  = cnt_q == (AW+1)'(DEPTH);
    assign rd    = pop & ~empty;
    assign wr    = push & (~full | rd);
    assign cnt_d = cnt_q + (AW+1)'(wr) - (AW+1)'(rd);
    assign dout  = mem[rp_q];
    assign count = cnt_q;

    always_ff @(posedge clk)
        if (wr) mem[wp_q] <= din;

    // Pointers are AW bits wide, so they wrap modulo DEPTH on their own
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            wp_q  <= '0;
            rp_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (wr) wp_q <= wp_q + 1'b1;
            if (rd) rp_q <= rp_q + 1'b1;
            cnt_q <= cnt_d;
        end
endmodule

// File: rtl/jtframe_dwnld_buf.sv
// jtframe_dwnld_buf: ioctl byte stream to SDRAM prog bus, buffered through a FIFO and drained by a we/ack/rdy FSM.
// Optional PROM bypass enabled by defining JTFRAME_DWNLD_PROM_EN.
module jtframe_dwnld_buf
    import jtframe_dwnld_pkg::*;
#(
    parameter logic [24:0] BA1_START  = 25'h100000,
    parameter logic [24:0] BA2_START  = 25'h200000,
    parameter logic [24:0] BA3_START  = 25'h300000,
    parameter logic [24:0] PROM_START = 25'h400000,
    parameter bit          SWAB       = 1'b1,
    parameter int          DEPTH      = 8
)(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        downloading,
    input  logic [24:0] ioctl_addr,
    input  logic [7:0]  ioctl_dout,
    input  logic        ioctl_wr,
    output logic [21:0] prog_addr,
    output logic [15:0] prog_data,
    output logic [1:0]  prog_mask,
    output logic [1:0]  prog_ba,
    output logic        prog_we,
    output logic        prog_rd,
    input  logic        prog_ack,
    input  logic        prog_rdy,
    output logic        prom_we,
    output logic        dwnld_busy,
    output logic        overflow
);
    localparam int AW = $clog2(DEPTH);

    state_t      state_q;
    entry_t      din, head;
    logic [1:0]  ba;
    logic [24:0] base;
    logic [22:0] off;
    logic [AW:0] cnt;
    logic        full, empty, push, pop, is_prom;
    logic [15:0] prog_data_q;
    logic        dl_q, ovf_q, busy_q;

    always_comb begin
        ba   = ioctl_addr >= BA3_START ? 2'd3 : ioctl_addr >= BA2_START ? 2'd2 :
               ioctl_addr >= BA1_START ? 2'd1 : 2'd0;
        base = ba == 2'd3 ? BA3_START : ba == 2'd2 ? BA2_START : ba == 2'd1 ? BA1_START : '0;
    end

    assign off = 23'(ioctl_addr - base);
    assign din = '{ba: ba, addr: off[22:1], data: {2{ioctl_dout}},
                   mask: off[0] ^ ~SWAB ? MASK_LO : MASK_HI};
    assign push = ioctl_wr & downloading & ~is_prom;
    assign pop  = state_q == REQ & prog_ack;
    assign prog_rd    = 1'b0;
    assign dwnld_busy = busy_q;
    assign overflow   = ovf_q;

`ifdef JTFRAME_DWNLD_PROM_EN
    logic       prom_we_q;
    logic [7:0] prom_data_q;
    assign is_prom = ioctl_addr >= PROM_START;
    assign prom_we = prom_we_q;
    // PROM byte shares the low lane only while no SDRAM request is being presented
    assign prog_data = state_q == IDLE ? {prog_data_q[15:8], prom_data_q} : prog_data_q;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            prom_we_q   <= 1'b0;
            prom_data_q <= '0;
        end else begin
            prom_we_q <= ioctl_wr & downloading & is_prom;
            if (ioctl_wr & downloading & is_prom) prom_data_q <= ioctl_dout;
        end
`else
    assign is_prom   = 1'b0 && ioctl_addr >= PROM_START;
    assign prom_we   = 1'b0;
    assign prog_data = prog_data_q;
`endif

    jtframe_dwnld_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .din   (din),
        .dout  (head),
        .full  (full),
        .empty (empty),
        .count (cnt)
    );

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state_q     <= IDLE;
            prog_we     <= 1'b0;
            prog_ba     <= '0;
            prog_addr   <= '0;
            prog_data_q <= '0;
            prog_mask   <= 2'b11;
        end else begin
            case (state_q)
                IDLE: if (!empty) begin
                    {prog_ba, prog_addr, prog_data_q, prog_mask} <= head;
                    prog_we <= 1'b1;
                    state_q <= REQ;
                end
                REQ: if (prog_ack) begin
                    prog_we <= 1'b0;
                    state_q <= prog_rdy ? IDLE : WAIT;
                end
                WAIT: if (prog_rdy) state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            dl_q   <= 1'b0;
            ovf_q  <= 1'b0;
            busy_q <= 1'b0;
        end else begin
            dl_q   <= downloading;
            busy_q <= downloading | cnt != '0 | state_q != IDLE;
            if (downloading & ~dl_q) ovf_q <= 1'b0;
            else if (push & full & ~pop) ovf_q <= 1'b1;
        end
endmodule

// File: tb/tb_jtframe_dwnld_buf.sv
// tb_jtframe_dwnld_buf: directed checks of decode, lanes, FIFO full/overflow, drain handshake and reset.
module tb_jtframe_dwnld_buf;
    logic        clk = 0, rst_n = 0, downloading = 0, ioctl_wr = 0, prog_ack = 0, prog_rdy = 0;
    logic [24:0] ioctl_addr = '0;
    logic [7:0]  ioctl_dout = '0;
    logic [21:0] prog_addr;
    logic [15:0] prog_data;
    logic [1:0]  prog_mask, prog_ba;
    logic        prog_we, prog_rd, prom_we, dwnld_busy, overflow;
    int          n_cmp = 0, n_err = 0;
    logic [1:0]  g_ba, g_m;
    logic [21:0] g_a;
    logic [15:0] g_d;

    jtframe_dwnld_buf dut (
        .clk(clk), .rst_n(rst_n), .downloading(downloading), .ioctl_addr(ioctl_addr),
        .ioctl_dout(ioctl_dout), .ioctl_wr(ioctl_wr), .prog_addr(prog_addr), .prog_data(prog_data),
        .prog_mask(prog_mask), .prog_ba(prog_ba), .prog_we(prog_we), .prog_rd(prog_rd),
        .prog_ack(prog_ack), .prog_rdy(prog_rdy), .prom_we(prom_we), .dwnld_busy(dwnld_busy),
        .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic wr(input logic [24:0] a, input logic [7:0] d);
        ioctl_addr = a;
        ioctl_dout = d;
        ioctl_wr   = 1;
        @(negedge clk);
        ioctl_wr   = 0;
    endtask

    // Wait for a request, capture it, then ack and complete in the same cycle
    task automatic drain(output logic [1:0] ba, output logic [21:0] a, output logic [15:0] d,
                         output logic [1:0] m);
        int n = 0;
        while (!prog_we && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("drain_req_seen", prog_we, 1);
        ba = prog_ba; a = prog_addr; d = prog_data; m = prog_mask;
        prog_ack = 1;
        prog_rdy = 1;
        @(negedge clk);
        prog_ack = 0;
        prog_rdy = 0;
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check("rst_we", prog_we, 0);
        check("rst_mask", prog_mask, 2'b11);
        check("rst_busy", dwnld_busy, 0);
        check("rst_ovf", overflow, 0);
        check("rst_rd", prog_rd, 0);
        check("rst_prom", prom_we, 0);
        rst_n = 1;
        @(negedge clk);

        // writes outside a download are ignored
        wr(25'h000010, 8'h77);
        @(negedge clk);
        check("idle_wr_cnt", dut.cnt, 0);
        check("idle_wr_we", prog_we, 0);

        // single byte, delayed ack then delayed rdy
        downloading = 1;
        wr(25'h000001, 8'hA5);
        check("single_we_early", prog_we, 0);
        @(negedge clk);
        check("single_we", prog_we, 1);
        check("single_ba", prog_ba, 0);
        check("single_addr", prog_addr, 0);
        check("single_data", prog_data, 16'hA5A5);
        check("single_mask", prog_mask, 2'b10);
        downloading = 0;
        repeat (2) @(negedge clk);
        check("single_hold", {prog_we, prog_data}, {1'b1, 16'hA5A5});
        prog_ack = 1;
        @(negedge clk);
        prog_ack = 0;
        check("single_we_drop", prog_we, 0);
        @(negedge clk);
        prog_rdy = 1;
        @(negedge clk);
        prog_rdy = 0;
        check("single_busy_rdy", dwnld_busy, 1);
        @(negedge clk);
        check("single_busy_fall", dwnld_busy, 0);

        // bank decode
        downloading = 1;
        wr(25'h100004, 8'h11);
        wr(25'h2FFFFF, 8'h22);
        wr(25'h300000, 8'h33);
        drain(g_ba, g_a, g_d, g_m);
        check("dec1", {g_ba, g_a, g_d, g_m}, {2'd1, 22'h000002, 16'h1111, 2'b01});
        drain(g_ba, g_a, g_d, g_m);
        check("dec2", {g_ba, g_a, g_d, g_m}, {2'd2, 22'h07FFFF, 16'h2222, 2'b10});
        drain(g_ba, g_a, g_d, g_m);
        check("dec3", {g_ba, g_a, g_d, g_m}, {2'd3, 22'h000000, 16'h3333, 2'b01});

        // without the PROM bypass this byte goes to bank 3
        wr(25'h400010, 8'h44);
        check("prom_pulse", prom_we, 0);
        drain(g_ba, g_a, g_d, g_m);
        check("prom_as_ba3", {g_ba, g_a, g_d}, {2'd3, 22'h080008, 16'h4444});

        // overflow: 9 writes with ack held low
        for (int i = 0; i < 9; i++) wr(25'(i), 8'h10 + 8'(i));
        check("ovf_set", overflow, 1);
        check("ovf_cnt", dut.cnt, 8);
        for (int i = 0; i < 8; i++) begin
            drain(g_ba, g_a, g_d, g_m);
            check("ovf_order", g_d, {2{8'h10 + 8'(i)}});
        end
        repeat (2) @(negedge clk);
        check("ovf_no_ninth", prog_we, 0);
        check("ovf_sticky", overflow, 1);
        downloading = 0;
        @(negedge clk);
        downloading = 1;
        @(negedge clk);
        check("ovf_clear", overflow, 0);

        // full FIFO, push in the same cycle as the pop
        for (int i = 0; i < 8; i++) wr(25'(i), 8'h20 + 8'(i));
        check("full_cnt", dut.cnt, 8);
        check("full_head", prog_data, 16'h2020);
        ioctl_addr = 25'h000008;
        ioctl_dout = 8'hEE;
        ioctl_wr = 1;
        prog_ack = 1;
        prog_rdy = 1;
        @(negedge clk);
        ioctl_wr = 0;
        prog_ack = 0;
        prog_rdy = 0;
        check("full_pop_ovf", overflow, 0);
        check("full_pop_cnt", dut.cnt, 8);
        for (int i = 1; i < 9; i++) begin
            drain(g_ba, g_a, g_d, g_m);
            check("full_order", g_d, i == 8 ? 16'hEEEE : {2{8'h20 + 8'(i)}});
        end

        // reset while a request is outstanding
        wr(25'h000002, 8'h55);
        @(negedge clk);
        check("rreq_we", prog_we, 1);
        rst_n = 0;
        #1;
        check("rreq_we0", prog_we, 0);
        check("rreq_busy0", dwnld_busy, 0);
        check("rreq_mask", prog_mask, 2'b11);
        @(negedge clk);
        rst_n = 1;
        @(negedge clk);
        check("rreq_empty", dut.cnt, 0);
        wr(25'h000003, 8'h66);
        check("rreq_cnt1", dut.cnt, 1);
        drain(g_ba, g_a, g_d, g_m);
        check("rreq_next", {g_a, g_d, g_m}, {22'h000001, 16'h6666, 2'b10});
        downloading = 0;
        repeat (2) @(negedge clk);
        check("end_busy", dwnld_busy, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
